// File: rtl/seven_seg_digit_decoder_pkg.sv
// Shared 7-segment glyph constants and the combinational value-to-pattern decode.
// Patterns are logical (1 = lit) in gfedcba order; polarity is applied by the user.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_ALL   = 7'h7F;

  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_A = 7'h77;
  localparam seg_t SEG_B = 7'h7C;
  localparam seg_t SEG_C = 7'h39;
  localparam seg_t SEG_D = 7'h5E;
  localparam seg_t SEG_E = 7'h79;
  localparam seg_t SEG_F = 7'h71;

  // Values 10-15 blank unless hex glyphs are enabled; unknown values fall to blank.
  function automatic seg_t seg_decode(input logic [3:0] value, input logic hex_en);
    seg_t hex_glyph;
    seg_t result;
    hex_glyph = SEG_BLANK;
    result    = SEG_BLANK;
    case (value)
      4'd10:   hex_glyph = SEG_A;
      4'd11:   hex_glyph = SEG_B;
      4'd12:   hex_glyph = SEG_C;
      4'd13:   hex_glyph = SEG_D;
      4'd14:   hex_glyph = SEG_E;
      4'd15:   hex_glyph = SEG_F;
      default: hex_glyph = SEG_BLANK;
    endcase
    case (value)
      4'd0:    result = SEG_0;
      4'd1:    result = SEG_1;
      4'd2:    result = SEG_2;
      4'd3:    result = SEG_3;
      4'd4:    result = SEG_4;
      4'd5:    result = SEG_5;
      4'd6:    result = SEG_6;
      4'd7:    result = SEG_7;
      4'd8:    result = SEG_8;
      4'd9:    result = SEG_9;
      4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15:
               result = hex_en ? hex_glyph : SEG_BLANK;
      default: result = SEG_BLANK;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/seven_seg_digit_decoder_if.sv
// Digit control/drive bundle: display controls in, registered segment pattern out.
interface seven_seg_digit_decoder_if;
  logic       lamp_test;
  logic       blank;
  logic [3:0] value;
  logic [6:0] segment;

  modport master (output lamp_test, output blank, output value, input segment);
  modport slave  (input lamp_test, input blank, input value, output segment);
endinterface

// File: rtl/seven_seg_digit_decoder.sv
// One display digit: priority (lamp test > blank > decode), polarity, output register.
module seven_seg_digit_decoder
  import seven_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_EN     = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  seven_seg_digit_decoder_if.slave   bus
);

  localparam seg_t POLARITY = {7{ACTIVE_LOW}};

  seg_t pattern;

  always_comb begin
    pattern = SEG_BLANK;
    if (bus.lamp_test)
      pattern = SEG_ALL;
    else if (bus.blank)
      pattern = SEG_BLANK;
    else
      pattern = seg_decode(bus.value, HEX_EN);
  end

  always_ff @(posedge clock) begin
    if (reset)
      bus.segment <= SEG_BLANK ^ POLARITY;
    else
      bus.segment <= pattern ^ POLARITY;
  end

endmodule

// File: tb/tb_seven_seg_digit_decoder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a table model.
module tb_seven_seg_digit_decoder;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  seven_seg_digit_decoder_if if_dec ();
  seven_seg_digit_decoder_if if_hex ();
  seven_seg_digit_decoder_if if_al ();
  seven_seg_digit_decoder_if if_tens ();
  seven_seg_digit_decoder_if if_ones ();

  seven_seg_digit_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) dut_dec
    (.clock(clock), .reset(reset), .bus(if_dec));
  seven_seg_digit_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) dut_hex
    (.clock(clock), .reset(reset), .bus(if_hex));
  seven_seg_digit_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) dut_al
    (.clock(clock), .reset(reset), .bus(if_al));
  seven_seg_digit_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) dut_tens
    (.clock(clock), .reset(reset), .bus(if_tens));
  seven_seg_digit_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) dut_ones
    (.clock(clock), .reset(reset), .bus(if_ones));

  // Logical glyphs for 0..F, gfedcba order.
  logic [6:0] glyph_tbl [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] model(bit al, bit hex, bit rst, bit lt, bit bl, logic [3:0] v);
    logic [6:0] p;
    if (rst)                  p = 7'h00;
    else if (lt)              p = 7'h7F;
    else if (bl)              p = 7'h00;
    else if (v < 10 || hex)   p = glyph_tbl[v];
    else                      p = 7'h00;
    return al ? ~p : p;
  endfunction

  task automatic drive_all(bit lt, bit bl, logic [3:0] v);
    if_dec.lamp_test = lt; if_dec.blank = bl; if_dec.value = v;
    if_hex.lamp_test = lt; if_hex.blank = bl; if_hex.value = v;
    if_al.lamp_test  = lt; if_al.blank  = bl; if_al.value  = v;
  endtask

  task automatic drive_count(int count);
    if_tens.lamp_test = 1'b0; if_tens.blank = 1'b0; if_tens.value = 4'(count / 10);
    if_ones.lamp_test = 1'b0; if_ones.blank = 1'b0; if_ones.value = 4'(count % 10);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_all(1'b0, 1'b0, 4'd8);
    drive_count(0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (if_dec.segment !== 7'h00) begin
        failures++;
        $display("FAIL reset_dec cycle=%0d got=%h exp=%h", i, if_dec.segment, 7'h00);
      end
      checks++;
      if (if_al.segment !== 7'h7F) begin
        failures++;
        $display("FAIL reset_al cycle=%0d got=%h exp=%h", i, if_al.segment, 7'h7F);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (if_dec.segment !== 7'h7F) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", if_dec.segment, 7'h7F);
    end
  endtask

  task automatic test_decimal_sweep();
    logic [6:0] exp_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [6:0] prev;
    prev = if_dec.segment;
    for (int v = 0; v < 10; v++) begin
      drive_all(1'b0, 1'b0, 4'(v));
      #1;
      checks++;
      if (if_dec.segment !== prev) begin
        failures++;
        $display("FAIL sweep_hold v=%0d got=%h exp=%h", v, if_dec.segment, prev);
      end
      tick();
      checks++;
      if (if_dec.segment !== exp_tbl[v]) begin
        failures++;
        $display("FAIL sweep_value v=%0d got=%h exp=%h", v, if_dec.segment, exp_tbl[v]);
      end
      prev = exp_tbl[v];
    end
  endtask

  task automatic test_hex_range();
    logic [6:0] exp_tbl [0:5] = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int v = 10; v < 16; v++) begin
      drive_all(1'b0, 1'b0, 4'(v));
      tick();
      checks++;
      if (if_hex.segment !== exp_tbl[v-10]) begin
        failures++;
        $display("FAIL hex_on v=%0d got=%h exp=%h", v, if_hex.segment, exp_tbl[v-10]);
      end
      checks++;
      if (if_dec.segment !== 7'h00) begin
        failures++;
        $display("FAIL hex_off v=%0d got=%h exp=%h", v, if_dec.segment, 7'h00);
      end
    end
  endtask

  task automatic test_priority();
    drive_all(1'b0, 1'b1, 4'd3);
    tick();
    checks++;
    if (if_dec.segment !== 7'h00) begin
      failures++;
      $display("FAIL prio_blank got=%h exp=%h", if_dec.segment, 7'h00);
    end
    drive_all(1'b1, 1'b1, 4'd3);
    tick();
    checks++;
    if (if_dec.segment !== 7'h7F) begin
      failures++;
      $display("FAIL prio_lamp got=%h exp=%h", if_dec.segment, 7'h7F);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (if_dec.segment !== 7'h00) begin
      failures++;
      $display("FAIL prio_reset got=%h exp=%h", if_dec.segment, 7'h00);
    end
    reset = 1'b0;
    drive_all(1'b0, 1'b0, 4'd3);
    tick();
    checks++;
    if (if_dec.segment !== 7'h4F) begin
      failures++;
      $display("FAIL prio_resume got=%h exp=%h", if_dec.segment, 7'h4F);
    end
  endtask

  task automatic test_polarity();
    drive_all(1'b0, 1'b0, 4'd0);
    tick();
    checks++;
    if (if_al.segment !== 7'h40) begin
      failures++;
      $display("FAIL pol_zero got=%h exp=%h", if_al.segment, 7'h40);
    end
    drive_all(1'b0, 1'b0, 4'd1);
    tick();
    checks++;
    if (if_al.segment !== 7'h79) begin
      failures++;
      $display("FAIL pol_one got=%h exp=%h", if_al.segment, 7'h79);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (if_al.segment !== 7'h7F) begin
      failures++;
      $display("FAIL pol_reset got=%h exp=%h", if_al.segment, 7'h7F);
    end
    reset = 1'b0;
  endtask

  task automatic test_paired();
    int counts [0:2] = '{42, 100, 7};
    for (int i = 0; i < 3; i++) begin
      logic [6:0] exp_t;
      logic [6:0] exp_o;
      int tens_d;
      tens_d = counts[i] / 10;
      exp_t = (tens_d < 10) ? glyph_tbl[tens_d] : 7'h00;
      exp_o = glyph_tbl[counts[i] % 10];
      drive_count(counts[i]);
      tick();
      checks++;
      if (if_tens.segment !== exp_t) begin
        failures++;
        $display("FAIL pair_tens count=%0d got=%h exp=%h", counts[i], if_tens.segment, exp_t);
      end
      checks++;
      if (if_ones.segment !== exp_o) begin
        failures++;
        $display("FAIL pair_ones count=%0d got=%h exp=%h", counts[i], if_ones.segment, exp_o);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      bit rst, lt, bl;
      logic [3:0] v;
      int cnt;
      logic [6:0] e_dec, e_hex, e_al, e_t, e_o;
      rst = ($urandom_range(0, 15) == 0);
      lt  = ($urandom_range(0, 7) == 0);
      bl  = ($urandom_range(0, 7) == 0);
      v   = 4'($urandom_range(0, 15));
      cnt = $urandom_range(0, 100);
      reset = rst;
      drive_all(lt, bl, v);
      drive_count(cnt);
      e_dec = model(1'b0, 1'b0, rst, lt, bl, v);
      e_hex = model(1'b0, 1'b1, rst, lt, bl, v);
      e_al  = model(1'b1, 1'b1, rst, lt, bl, v);
      e_t   = model(1'b0, 1'b0, rst, 1'b0, 1'b0, 4'(cnt / 10));
      e_o   = model(1'b0, 1'b0, rst, 1'b0, 1'b0, 4'(cnt % 10));
      tick();
      checks++;
      if (if_dec.segment !== e_dec) begin
        failures++;
        $display("FAIL rand_dec n=%0d r=%0b lt=%0b bl=%0b v=%0d got=%h exp=%h",
                 n, rst, lt, bl, v, if_dec.segment, e_dec);
      end
      checks++;
      if (if_hex.segment !== e_hex) begin
        failures++;
        $display("FAIL rand_hex n=%0d r=%0b lt=%0b bl=%0b v=%0d got=%h exp=%h",
                 n, rst, lt, bl, v, if_hex.segment, e_hex);
      end
      checks++;
      if (if_al.segment !== e_al) begin
        failures++;
        $display("FAIL rand_al n=%0d r=%0b lt=%0b bl=%0b v=%0d got=%h exp=%h",
                 n, rst, lt, bl, v, if_al.segment, e_al);
      end
      checks++;
      if (if_tens.segment !== e_t || if_ones.segment !== e_o) begin
        failures++;
        $display("FAIL rand_pair n=%0d count=%0d got=%h/%h exp=%h/%h",
                 n, cnt, if_tens.segment, if_ones.segment, e_t, e_o);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive_all(1'b0, 1'b0, 4'd0);
    drive_count(0);
    #2;
    test_reset();
    test_decimal_sweep();
    test_hex_range();
    test_priority();
    test_polarity();
    test_paired();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
